frame_reception: RTL
====================

# frame_reception

Byte-wide Ethernet frame receiver, the receive-side counterpart of `frame_transmission`. It hunts for the preamble and SFD and parses the destination address, source address, EtherType and a fixed 4-byte payload. It then checks the 4 trailing CRC bytes against a locally computed CRC-32 and presents the parsed fields with a one-cycle valid/error indication. It sits between the PHY-side byte stream and the MAC upper layer.

## Interface
- `MAC_ADDR`, default 48'h02_00_00_00_00_01: station address. Used only when `FRAME_RX_ADDR_FILTER_EN` is defined.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `rx_data`  in  8: received byte, sampled when `rx_dv`=1.
- `rx_dv`  in  1: byte valid. Held high for the whole frame.
- `dest_addr`  out  48: captured destination address.
- `src_addr`  out  48: captured source address.
- `eth_type`  out  16: captured EtherType.
- `data_out`  out  32: captured payload. The first received byte is in [31:24].
- `rx_valid`  out  1: 1-cycle pulse; frame accepted with a good CRC.
- `crc_err`  out  1: 1-cycle pulse; frame complete but CRC mismatch.
- `frame_err`  out  1: 1-cycle pulse; `rx_dv` dropped mid-frame (truncation).
- `busy`  out  1: high in every state except IDLE.
- `state`  out  4: current FSM state, for debug.

## Operation
- **States** are IDLE, PREAMBLE, DEST_ADDR, SRC_ADDR, ETH_TYPE, PAYLOAD, CRC, WAIT_IDLE.
- **IDLE.** A byte 8'hAA with `rx_dv` high moves the FSM to PREAMBLE with `pre_cnt`=1.
- **PREAMBLE.**
  - Each 8'hAA increments `pre_cnt`, saturating at 7.
  - 8'hAB with `pre_cnt`≥7 moves to DEST_ADDR with `byte_cnt`=0.
  - 8'hAB with `pre_cnt`<7, or any other byte, moves to WAIT_IDLE. No error is flagged.
- **DEST_ADDR and SRC_ADDR.** 6 bytes each, MSB byte first. `byte_cnt` counts 0..5 and then resets to 0.
- **ETH_TYPE.** 2 bytes, MSB first.
- **PAYLOAD.** 4 bytes, MSB first. Each byte is fed to the CRC engine.
- **CRC.** 4 bytes, assembled MSB first into `rx_crc`.
  - On the 4th byte, compare `{rx_crc[31:8], rx_data}` with the computed CRC.
  - Match: pulse `rx_valid`. Mismatch: pulse `crc_err`.
  - Then go to WAIT_IDLE.
- **CRC algorithm.** CRC-32, polynomial 32'h04C11DB7, init 32'hFFFFFFFF, MSB-first bit order, no final XOR. Coverage is the payload bytes only, to match the transmitter.
- **Shadow output registers.** Fields are captured into internal registers. They are copied to `dest_addr`, `src_addr`, `eth_type` and `data_out` only on the cycle `rx_valid` asserts. The outputs therefore hold the last good frame and are unchanged by bad frames.
- **WAIT_IDLE.** Ignores bytes until `rx_dv`=0, then goes to IDLE. Trailing bytes after the CRC are discarded.
- **Truncation.** If `rx_dv`=0 in any of DEST_ADDR..CRC, pulse `frame_err` and go to IDLE. The CRC is re-initialised.
- **CRC reset.** The CRC register is set to its initial value whenever the FSM enters DEST_ADDR.

## Timing
- **Reset.**
  - All outputs are 0. `state` = IDLE (4'h0).
  - Counters are 0 and the CRC register is 32'hFFFFFFFF.
- **Register stages.** `rx_data`/`rx_dv` are registered once, and all outputs are registered.
- **Latency.** `rx_valid`, `crc_err` and `frame_err` assert for exactly one cycle, 2 clocks after the edge on which the last CRC byte (or the `rx_dv` drop) is presented.
  - At most one of the three pulses is asserted in any cycle.
- **Back-to-back frames.** The next frame requires at least 1 cycle of `rx_dv`=0. No gap is required between frames and the output pulse.
- **Reset mid-frame.** Return to IDLE immediately. No error pulse is produced and shadow outputs are cleared.

## Configuration
- **`FRAME_RX_ADDR_FILTER_EN` defined.** After DEST_ADDR completes, the captured address is checked. If it is neither `MAC_ADDR` nor 48'hFFFF_FFFF_FFFF, go to WAIT_IDLE silently: no pulse and no output update.
- **`FRAME_RX_ADDR_FILTER_EN` undefined.** All addresses are accepted and `MAC_ADDR` is unused.

## Structure
- **Package `eth_frame_pkg`** holds:
  - the state encoding (4-bit localparams)
  - `PREAMBLE_BYTE`=8'hAA, `SFD_BYTE`=8'hAB, `PREAMBLE_MIN`=7
  - field byte lengths (6, 6, 2, 4, 4)
  - `CRC_POLY` and `CRC_INIT`

  `frame_transmission` is to be migrated onto the same package.
- **Sub-module `crc32_byte`.** Signals: `clk`, `rst_n`, `init`, `en`, `data[7:0]`, `crc[31:0]`. It is a registered byte-serial update, and is shared with the transmit path.

## Test plan
- **Good frame.** 7×AA, AB; dest 02_00_00_00_00_01; src 0A_0B_0C_0D_0E_0F; type 0800; payload DEADBEEF; CRC from the bench model → `rx_valid` 1 cycle; outputs equal the sent fields; `crc_err`=`frame_err`=0.
- **Bad CRC.** Same frame with the last CRC byte XOR 8'h01 → `crc_err` 1 cycle; `rx_valid`=0; outputs keep the previous good frame.
- **Truncation.** `rx_dv` drops after the 2nd payload byte → `frame_err` 1 cycle; `state` returns to IDLE; next good frame is accepted.
- **Short preamble and noise.**
  - 5×AA then AB → no pulse.
  - 3×AA, 55, 7×AA, AB → no pulse until `rx_dv` low; a following good frame gives `rx_valid`.
- **Long preamble and trailing bytes.** 12×AA, AB, good frame, then 3 junk bytes with `rx_dv` high → exactly one `rx_valid`.
- **Filter and reset.**
  - With `FRAME_RX_ADDR_FILTER_EN`: dest 02_00_00_00_00_99 → no pulse; dest FF…FF → `rx_valid`.
  - Assert `rst_n` during SRC_ADDR → all outputs 0, no pulse.

Source files
------------

// File: rtl/eth_frame_pkg.sv
// Shared Ethernet framing constants, FSM encoding and the byte-wise CRC-32 step,
// common to the receive and transmit paths.
package eth_frame_pkg;

    localparam logic [3:0] STATE_IDLE      = 4'h0;
    localparam logic [3:0] STATE_PREAMBLE  = 4'h1;
    localparam logic [3:0] STATE_DEST_ADDR = 4'h2;
    localparam logic [3:0] STATE_SRC_ADDR  = 4'h3;
    localparam logic [3:0] STATE_ETH_TYPE  = 4'h4;
    localparam logic [3:0] STATE_PAYLOAD   = 4'h5;
    localparam logic [3:0] STATE_CRC       = 4'h6;
    localparam logic [3:0] STATE_WAIT_IDLE = 4'h7;

    typedef enum logic [3:0] {
        S_IDLE      = STATE_IDLE,
        S_PREAMBLE  = STATE_PREAMBLE,
        S_DEST_ADDR = STATE_DEST_ADDR,
        S_SRC_ADDR  = STATE_SRC_ADDR,
        S_ETH_TYPE  = STATE_ETH_TYPE,
        S_PAYLOAD   = STATE_PAYLOAD,
        S_CRC       = STATE_CRC,
        S_WAIT_IDLE = STATE_WAIT_IDLE
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0]  SFD_BYTE      = 8'hAB;
    localparam logic [2:0]  PREAMBLE_MIN  = 3'd7;

    localparam logic [2:0]  DEST_LEN    = 3'd6;
    localparam logic [2:0]  SRC_LEN     = 3'd6;
    localparam logic [2:0]  TYPE_LEN    = 3'd2;
    localparam logic [2:0]  PAYLOAD_LEN = 3'd4;
    localparam logic [2:0]  CRC_LEN     = 3'd4;

    localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    // MSB-first CRC-32 over one byte, no reflection, no final XOR.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {data, 24'h0};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Registered byte-serial CRC-32 engine; init has priority over en.
module crc32_byte
    import eth_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_update(crc, data);
        end
    end

endmodule

// File: rtl/frame_reception.sv
// Byte-wide Ethernet frame receiver: preamble/SFD hunt, header and payload parse, CRC-32 check.
// Optional destination filtering is enabled by defining FRAME_RX_ADDR_FILTER_EN.
module frame_reception
    import eth_frame_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_dv,
    output logic [47:0] dest_addr,
    output logic [47:0] src_addr,
    output logic [15:0] eth_type,
    output logic [31:0] data_out,
    output logic        rx_valid,
    output logic        crc_err,
    output logic        frame_err,
    output logic        busy,
    output logic [3:0]  state
);

    rx_state_t   state_q, state_d;
    logic [7:0]  rx_data_q;
    logic        rx_dv_q;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [47:0] dest_sh_q, dest_sh_d;
    logic [47:0] src_sh_q, src_sh_d;
    logic [15:0] type_sh_q, type_sh_d;
    logic [31:0] pay_sh_q, pay_sh_d;
    logic [23:0] rx_crc_q, rx_crc_d;
    logic        rx_valid_d, crc_err_d, frame_err_d;
    logic        crc_init, crc_en;
    logic [31:0] crc_calc;
    logic        in_frame;
    logic [47:0] dest_full;
    logic        addr_match, addr_ok;

    crc32_byte u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init),
        .en    (crc_en),
        .data  (rx_data_q),
        .crc   (crc_calc)
    );

    assign dest_full  = {dest_sh_q[39:0], rx_data_q};
    assign addr_match = (dest_full == MAC_ADDR) || (dest_full == BCAST_ADDR);
`ifdef FRAME_RX_ADDR_FILTER_EN
    assign addr_ok = addr_match;
`else
    // No filtering: every destination is accepted.
    assign addr_ok = 1'b1 | addr_match;
`endif

    assign in_frame = (state_q == S_DEST_ADDR) || (state_q == S_SRC_ADDR) ||
                      (state_q == S_ETH_TYPE)  || (state_q == S_PAYLOAD)  ||
                      (state_q == S_CRC);
    assign state = state_q;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        dest_sh_d   = dest_sh_q;
        src_sh_d    = src_sh_q;
        type_sh_d   = type_sh_q;
        pay_sh_d    = pay_sh_q;
        rx_crc_d    = rx_crc_q;
        rx_valid_d  = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        crc_init    = 1'b0;
        crc_en      = 1'b0;

        if (in_frame && !rx_dv_q) begin
            // Truncated frame: report it and rearm for the next preamble.
            frame_err_d = 1'b1;
            crc_init    = 1'b1;
            byte_cnt_d  = 3'd0;
            pre_cnt_d   = 3'd0;
            state_d     = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pre_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                    if (rx_dv_q && rx_data_q == PREAMBLE_BYTE) begin
                        pre_cnt_d = 3'd1;
                        state_d   = S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (!rx_dv_q) begin
                        state_d = S_IDLE;
                    end else if (rx_data_q == PREAMBLE_BYTE) begin
                        if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
                    end else if (rx_data_q == SFD_BYTE && pre_cnt_q >= PREAMBLE_MIN) begin
                        byte_cnt_d = 3'd0;
                        crc_init   = 1'b1;
                        state_d    = S_DEST_ADDR;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
                S_DEST_ADDR: begin
                    dest_sh_d = dest_full;
                    if (byte_cnt_q == DEST_LEN - 3'd1) begin
                        byte_cnt_d = 3'd0;
                        state_d    = addr_ok ? S_SRC_ADDR : S_WAIT_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
                S_SRC_ADDR: begin
                    src_sh_d = {src_sh_q[39:0], rx_data_q};
                    if (byte_cnt_q == SRC_LEN - 3'd1) begin
                        byte_cnt_d = 3'd0;
                        state_d    = S_ETH_TYPE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
                S_ETH_TYPE: begin
                    type_sh_d = {type_sh_q[7:0], rx_data_q};
                    if (byte_cnt_q == TYPE_LEN - 3'd1) begin
                        byte_cnt_d = 3'd0;
                        state_d    = S_PAYLOAD;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
                S_PAYLOAD: begin
                    pay_sh_d = {pay_sh_q[23:0], rx_data_q};
                    crc_en   = 1'b1;
                    if (byte_cnt_q == PAYLOAD_LEN - 3'd1) begin
                        byte_cnt_d = 3'd0;
                        state_d    = S_CRC;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
                S_CRC: begin
                    rx_crc_d = {rx_crc_q[15:0], rx_data_q};
                    if (byte_cnt_q == CRC_LEN - 3'd1) begin
                        // The last CRC byte is compared straight from the input register.
                        if ({rx_crc_q, rx_data_q} == crc_calc) rx_valid_d = 1'b1;
                        else                                   crc_err_d  = 1'b1;
                        byte_cnt_d = 3'd0;
                        state_d    = S_WAIT_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!rx_dv_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rx_data_q  <= 8'h00;
            rx_dv_q    <= 1'b0;
            pre_cnt_q  <= 3'd0;
            byte_cnt_q <= 3'd0;
            dest_sh_q  <= 48'h0;
            src_sh_q   <= 48'h0;
            type_sh_q  <= 16'h0;
            pay_sh_q   <= 32'h0;
            rx_crc_q   <= 24'h0;
            dest_addr  <= 48'h0;
            src_addr   <= 48'h0;
            eth_type   <= 16'h0;
            data_out   <= 32'h0;
            rx_valid   <= 1'b0;
            crc_err    <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_data_q  <= rx_data;
            rx_dv_q    <= rx_dv;
            pre_cnt_q  <= pre_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            dest_sh_q  <= dest_sh_d;
            src_sh_q   <= src_sh_d;
            type_sh_q  <= type_sh_d;
            pay_sh_q   <= pay_sh_d;
            rx_crc_q   <= rx_crc_d;
            rx_valid   <= rx_valid_d;
            crc_err    <= crc_err_d;
            frame_err  <= frame_err_d;
            busy       <= (state_d != S_IDLE);
            // Visible fields only ever show a frame that passed its CRC.
            if (rx_valid_d) begin
                dest_addr <= dest_sh_q;
                src_addr  <= src_sh_q;
                eth_type  <= type_sh_q;
                data_out  <= pay_sh_q;
            end
        end
    end

endmodule
